// File: rtl/mux_nto1_skid.sv
// Purpose: N-way WIDTH-bit operand select feeding the EX operand registers, with a 2-entry skid queue.
// Latency: 1 cycle from accept to data_o when the queue is empty or the head pops that same cycle.
// Backpressure: in_ready_o depends only on occupancy (low when both entries are full); flush_i drops all beats.
module mux_nto1_skid #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SEL_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               bad_o,
  output logic               err_o
);

  // Occupancy encoding: number of valid beats held (head, then skid)
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;

  logic [WIDTH-1:0] head_data_q;
  logic [SEL_W-1:0] head_sel_q;
  logic             head_bad_q;

  logic [WIDTH-1:0] skid_data_q;
  logic [SEL_W-1:0] skid_sel_q;
  logic             skid_bad_q;

  logic             err_q;

  logic [WIDTH-1:0] beat_data;
  logic             beat_bad;

  logic             accept;
  logic             push;

  logic             head_from_beat;
  logic             head_from_skid;
  logic             head_clr;
  logic             skid_load;
  logic             skid_clr;

  // Ready is a function of stored occupancy only, so no combinational path from out_ready_i
  assign in_ready_o  = (state_q != ST_TWO) & ~rst_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign push        = out_valid_o & out_ready_i;

  // Head registers are cleared whenever the queue drains, so outputs read as zero when idle
  assign data_o = head_data_q;
  assign sel_o  = head_sel_q;
  assign bad_o  = head_bad_q;
  assign err_o  = err_q;

  // Pick the incoming channel; an out-of-range select yields zero data and flags the beat
  always_comb begin
    beat_data = '0;
    beat_bad  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) begin
        beat_data = data_i[k*WIDTH +: WIDTH];
        beat_bad  = 1'b0;
      end
    end
  end

  // Occupancy transitions and register-update strobes; flush overrides everything
  always_comb begin
    state_d        = state_q;
    head_from_beat = 1'b0;
    head_from_skid = 1'b0;
    head_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d        = ST_ONE;
            head_from_beat = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && push) begin
            head_from_beat = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (push) begin
            state_d  = ST_EMPTY;
            head_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (push) begin
            state_d        = ST_ONE;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty queue
          state_d  = ST_EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Occupancy register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head entry: loads a fresh beat, promotes the skid entry, or clears when drained
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_bad_q  <= 1'b0;
    end else if (head_clr) begin
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_bad_q  <= 1'b0;
    end else if (head_from_beat) begin
      head_data_q <= beat_data;
      head_sel_q  <= sel_i;
      head_bad_q  <= beat_bad;
    end else if (head_from_skid) begin
      head_data_q <= skid_data_q;
      head_sel_q  <= skid_sel_q;
      head_bad_q  <= skid_bad_q;
    end
  end

  // Skid entry: captures the beat accepted while the head is stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_bad_q  <= 1'b0;
    end else if (skid_clr) begin
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_bad_q  <= 1'b0;
    end else if (skid_load) begin
      skid_data_q <= beat_data;
      skid_sel_q  <= sel_i;
      skid_bad_q  <= beat_bad;
    end
  end

  // Sticky error: any accepted out-of-range select, survives flush, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept && beat_bad) begin
      err_q <= 1'b1;
    end
  end

endmodule
